// File: rtl/ireg_writeback_if.sv
// Signal bundle between the issue/execute side and the write-back stage:
// ALU result, load handshake, register-file write port and pending-write lookup.
interface ireg_writeback_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_we;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_d;

  logic          ld_valid;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_d;
  logic          ld_ready;

  logic [AW-1:0] rw;
  logic [DW-1:0] dw;
  logic          we;

  logic [AW-1:0] q_r0;
  logic [AW-1:0] q_r1;
  logic          pend0;
  logic          pend1;

  logic [CW-1:0] fifo_cnt;
  logic          idle;

  modport master (
    output alu_we, alu_rd, alu_d,
    output ld_valid, ld_rd, ld_d,
    output q_r0, q_r1,
    input  ld_ready, rw, dw, we, pend0, pend1, fifo_cnt, idle
  );

  modport slave (
    input  alu_we, alu_rd, alu_d,
    input  ld_valid, ld_rd, ld_d,
    input  q_r0, q_r1,
    output ld_ready, rw, dw, we, pend0, pend1, fifo_cnt, idle
  );
endinterface

// File: rtl/ireg_writeback.sv
// Integer write-back stage: merges ALU results (priority) and FIFO-buffered
// load results onto the single register-file write port, with pending-load lookup.
module ireg_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input logic                clk,
  input logic                reset,
  ireg_writeback_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fifo_rd [DEPTH];
  logic [DW-1:0] fifo_d  [DEPTH];
  logic [DEPTH-1:0] fifo_v;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;

  logic          we_q;
  logic [AW-1:0] rw_q;
  logic [DW-1:0] dw_q;
  logic          src_fifo;

  logic ready;
  logic push;
  logic pop;
  logic p0;
  logic p1;

  // Readiness depends only on the registered count, never on a same-cycle pop.
  assign ready = (cnt != CW'(DEPTH));
  assign push  = bus.ld_valid & ready & ~reset;
  assign pop   = ~bus.alu_we & (cnt != '0) & ~reset;

  // Payload storage carries no reset; the valid bits alone mark live entries.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr] <= bus.ld_rd;
      fifo_d[wptr]  <= bus.ld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_v   <= '0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      we_q     <= 1'b0;
      rw_q     <= '0;
      dw_q     <= '0;
      src_fifo <= 1'b0;
    end else begin
      if (push) begin
        fifo_v[wptr] <= 1'b1;
        wptr         <= wptr + PW'(1);
      end
      if (pop) begin
        fifo_v[rptr] <= 1'b0;
        rptr         <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      // ALU wins the port; the queued load waits for a free cycle.
      if (bus.alu_we) begin
        we_q     <= 1'b1;
        rw_q     <= bus.alu_rd;
        dw_q     <= bus.alu_d;
        src_fifo <= 1'b0;
      end else if (pop) begin
        we_q     <= 1'b1;
        rw_q     <= fifo_rd[rptr];
        dw_q     <= fifo_d[rptr];
        src_fifo <= 1'b1;
      end else begin
        we_q     <= 1'b0;
        src_fifo <= 1'b0;
      end
    end
  end

  // A load stays pending until its write has actually left the port.
  always_comb begin
    p0 = we_q & src_fifo & (rw_q == bus.q_r0);
    p1 = we_q & src_fifo & (rw_q == bus.q_r1);
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_v[i] && (fifo_rd[i] == bus.q_r0)) p0 = 1'b1;
      if (fifo_v[i] && (fifo_rd[i] == bus.q_r1)) p1 = 1'b1;
    end
  end

  assign bus.ld_ready = ready;
  assign bus.we       = we_q;
  assign bus.rw       = rw_q;
  assign bus.dw       = dw_q;
  assign bus.pend0    = p0;
  assign bus.pend1    = p1;
  assign bus.fifo_cnt = cnt;
  assign bus.idle     = (cnt == '0) & ~we_q;
endmodule

// File: tb/tb_ireg_writeback.sv
// Randomized plus directed bench for ireg_writeback, checked every cycle
// against a queue-based model of the write-back stage.
module tb_ireg_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 6;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  ireg_writeback_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();

  ireg_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cmpCnt = 0;
  int errCnt = 0;

  ent_t          mq[$];
  bit            mWe  = 1'b0;
  logic [AW-1:0] mRw  = '0;
  logic [DW-1:0] mDw  = '0;
  bit            mSrc = 1'b0;
  bit            known = 1'b0;
  logic [DW-1:0] modelRf [64];
  logic [DW-1:0] dutRf   [64];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmpCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against model state, advance model.
  task automatic applyStimulus(input bit rst, input bit awe, input logic [AW-1:0] ard,
                               input logic [DW-1:0] ad, input bit lv, input logic [AW-1:0] lrd,
                               input logic [DW-1:0] ld, input logic [AW-1:0] q0,
                               input logic [AW-1:0] q1, output bit acc);
    bit expRdy, eP0, eP1;
    reset        = rst;
    bus.alu_we   = awe;
    bus.alu_rd   = ard;
    bus.alu_d    = ad;
    bus.ld_valid = lv;
    bus.ld_rd    = lrd;
    bus.ld_d     = ld;
    bus.q_r0     = q0;
    bus.q_r1     = q1;
    #1;
    expRdy = (mq.size() != DEPTH);
    eP0 = mWe && mSrc && (mRw == q0);
    eP1 = mWe && mSrc && (mRw == q1);
    foreach (mq[i]) begin
      if (mq[i].rd == q0) eP0 = 1'b1;
      if (mq[i].rd == q1) eP1 = 1'b1;
    end
    if (known) begin
      checkOutput("we",       32'(bus.we),       32'(mWe));
      checkOutput("rw",       32'(bus.rw),       32'(mRw));
      checkOutput("dw",       bus.dw,            mDw);
      checkOutput("ld_ready", 32'(bus.ld_ready), 32'(expRdy));
      checkOutput("fifo_cnt", 32'(bus.fifo_cnt), 32'(mq.size()));
      checkOutput("idle",     32'(bus.idle),     32'(mq.size() == 0 && !mWe));
      checkOutput("pend0",    32'(bus.pend0),    32'(eP0));
      checkOutput("pend1",    32'(bus.pend1),    32'(eP1));
      if (bus.we === 1'b1) dutRf[bus.rw] = bus.dw;
      if (mWe) modelRf[mRw] = mDw;
    end
    acc = 1'b0;
    if (rst) begin
      mq.delete();
      mWe = 1'b0; mRw = '0; mDw = '0; mSrc = 1'b0;
      known = 1'b1;
    end else begin
      acc = lv && expRdy;
      if (awe) begin
        mWe = 1'b1; mRw = ard; mDw = ad; mSrc = 1'b0;
      end else if (mq.size() > 0) begin
        mWe = 1'b1; mRw = mq[0].rd; mDw = mq[0].d; mSrc = 1'b1;
        void'(mq.pop_front());
      end else begin
        mWe = 1'b0; mSrc = 1'b0;
      end
      if (acc) mq.push_back('{lrd, ld});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n, input logic [AW-1:0] q0);
    bit a;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, '0, q0, 6'd0, a);
  endtask

  initial begin
    bit a;
    int idx;
    logic [DW-1:0] wrapData [3*DEPTH];
    for (int i = 0; i < 64; i++) begin
      modelRf[i] = '0;
      dutRf[i]   = '0;
    end

    // Reset held two cycles while both producers are active.
    applyStimulus(1, 1, 6'd9, 32'h1111, 1, 6'd9, 32'h2222, 6'd9, 6'd0, a);
    applyStimulus(1, 1, 6'd9, 32'h1111, 1, 6'd9, 32'h2222, 6'd9, 6'd0, a);
    quiet(2, 6'd9);

    // ALU only.
    applyStimulus(0, 1, 6'd5, 32'h3, 0, '0, '0, 6'd5, 6'd0, a);
    quiet(2, 6'd5);

    // Single load, pend0 watching r7.
    applyStimulus(0, 0, '0, '0, 1, 6'd7, 32'hDEADBEEF, 6'd7, 6'd0, a);
    checkOutput("load_accept", 32'(a), 32'd1);
    quiet(4, 6'd7);

    // ALU saturating the port while five loads queue up.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, c < 6, 6'(20 + c), 32'(100 + c), idx < 5, 6'(10 + idx),
                    32'(1000 + idx), 6'(10 + idx), 6'd13, a);
      if (a) idx++;
    end
    checkOutput("contention_accepts", 32'(idx), 32'd5);

    // Same destination from ALU and load in one cycle: load commits last.
    applyStimulus(0, 1, 6'd3, 32'd1, 1, 6'd3, 32'd2, 6'd3, 6'd3, a);
    quiet(4, 6'd3);
    checkOutput("rf3_final", dutRf[3], 32'd2);

    // Stream 3*DEPTH loads through the FIFO to exercise pointer wrap.
    idx = 0;
    for (int i = 0; i < 3*DEPTH; i++) wrapData[i] = $urandom;
    for (int c = 0; c < 6*DEPTH && idx < 3*DEPTH; c++) begin
      applyStimulus(0, 0, '0, '0, 1, 6'(40 + idx), wrapData[idx], 6'(40 + idx), 6'd41, a);
      if (a) idx++;
    end
    checkOutput("wrap_accepts", 32'(idx), 32'(3*DEPTH));
    quiet(DEPTH + 2, 6'd0);
    checkOutput("wrap_idle", 32'(bus.idle), 32'd1);
    for (int i = 0; i < 3*DEPTH; i++)
      checkOutput("wrap_rf", dutRf[40 + i], wrapData[i]);

    // Randomized traffic over a small register range so lookups hit often.
    for (int c = 0; c < 800; c++) begin
      applyStimulus(($urandom_range(0, 149) == 0), $urandom_range(0, 1),
                    6'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 9) < 7), 6'($urandom_range(0, 15)), $urandom,
                    6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), a);
    end
    quiet(DEPTH + 2, 6'd0);
    for (int i = 0; i < 64; i++) checkOutput("rf_final", dutRf[i], modelRf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end
endmodule
